// File: rtl/intersection_sched.sv
// Two-approach traffic intersection scheduler: alternating NS/EW right-of-way
// with pedestrian walk, emergency preemption and power-outage flash, timed by pulse_1s.
module intersection_sched #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int PED_WALK  = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulse_1s,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       nmi_preempt,
  input  logic       preempt_dir,
  input  logic       nmi_power_outage,
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       ped_pend_ns,
  output logic       ped_pend_ew,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_ALLRED = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;

  localparam logic [4:0] YEL_LD  = 5'(YELLOW_T - 1);
  localparam logic [4:0] AR_LD   = 5'(ALLRED_T - 1);
  localparam logic [4:0] WALK_LD = 5'(PED_WALK);

  logic [2:0] state_q, state_d;
  logic       dir_q, dir_d;
  logic       next_dir_q, next_dir_d;
  logic [4:0] timer_q, timer_d;
  logic [4:0] green_cnt_q, green_cnt_d;
  logic [4:0] walk_cnt_q, walk_cnt_d;
  logic       flash_togl_q, flash_togl_d;
  logic [1:0] pend_q, pend_d, pend_clr;
  logic [7:0] lamp_d;

  logic [5:0] elapsed;
  logic       other_dem, own_req, exit_ok;

  // elapsed counts the current pulse, so it is the number of pulses since green entry
  assign elapsed   = {1'b0, green_cnt_q} + 6'd1;
  assign other_dem = dir_q ? (req_ns | pend_q[0]) : (req_ew | pend_q[1]);
  assign own_req   = dir_q ? req_ew : req_ns;
  assign exit_ok   = (walk_cnt_q <= 5'd1) && other_dem && (elapsed >= 6'(GREEN_MIN)) &&
                     (!own_req || (elapsed >= 6'(GREEN_MAX)));

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    next_dir_d   = next_dir_q;
    timer_d      = timer_q;
    green_cnt_d  = green_cnt_q;
    walk_cnt_d   = walk_cnt_q;
    flash_togl_d = flash_togl_q;
    pend_clr     = 2'b00;
    if (pulse_1s) begin
      flash_togl_d = ~flash_togl_q;
      if (timer_q != 5'd0) timer_d = timer_q - 5'd1;
      if (nmi_power_outage) begin
        state_d = S_FLASH;
      end else begin
        case (state_q)
          S_RESET: begin
            state_d    = S_ALLRED;
            next_dir_d = 1'b0;
            timer_d    = AR_LD;
          end
          S_ALLRED: begin
            if (timer_q == 5'd0) begin
              state_d          = S_GREEN;
              dir_d            = nmi_preempt ? preempt_dir : next_dir_q;
              green_cnt_d      = 5'd0;
              walk_cnt_d       = pend_q[dir_d] ? WALK_LD : 5'd0;
              pend_clr[dir_d]  = 1'b1;
            end
          end
          S_GREEN: begin
            green_cnt_d = (green_cnt_q == 5'd31) ? green_cnt_q : green_cnt_q + 5'd1;
            if (walk_cnt_q != 5'd0) walk_cnt_d = walk_cnt_q - 5'd1;
            if (nmi_preempt) begin
              // preemption toward the served approach simply holds green
              if (preempt_dir != dir_q) begin
                state_d    = S_YELLOW;
                timer_d    = YEL_LD;
                walk_cnt_d = 5'd0;
              end
            end else if (exit_ok) begin
              state_d = S_YELLOW;
              timer_d = YEL_LD;
            end
          end
          S_YELLOW: begin
            if (timer_q == 5'd0) begin
              state_d    = S_ALLRED;
              next_dir_d = ~dir_q;
              timer_d    = AR_LD;
            end
          end
          S_FLASH: begin
            state_d    = S_ALLRED;
            next_dir_d = 1'b0;
            timer_d    = AR_LD;
          end
          default: state_d = S_RESET;
        endcase
      end
    end
  end

  // a button press on the same clk as the green-entry clear keeps the request
  assign pend_d = (pend_q & ~pend_clr) | {ped_req_ew, ped_req_ns};

  // lamp order: ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew
  always_comb begin
    lamp_d = 8'b0;
    case (state_q)
      S_ALLRED: lamp_d = 8'b0010_0100;
      S_GREEN:  lamp_d = dir_q ? {6'b001_100, 1'b0, walk_cnt_q != 5'd0}
                               : {6'b100_001, walk_cnt_q != 5'd0, 1'b0};
      S_YELLOW: lamp_d = dir_q ? 8'b0010_1000 : 8'b0100_0100;
      S_FLASH:  lamp_d = {2'b00, flash_togl_q, 2'b00, flash_togl_q, 2'b00};
      default:  lamp_d = 8'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RESET;
      dir_q        <= 1'b0;
      next_dir_q   <= 1'b0;
      timer_q      <= 5'd0;
      green_cnt_q  <= 5'd0;
      walk_cnt_q   <= 5'd0;
      flash_togl_q <= 1'b0;
      pend_q       <= 2'b00;
      {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk_ns, walk_ew} <= 8'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      next_dir_q   <= next_dir_d;
      timer_q      <= timer_d;
      green_cnt_q  <= green_cnt_d;
      walk_cnt_q   <= walk_cnt_d;
      flash_togl_q <= flash_togl_d;
      pend_q       <= pend_d;
      {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk_ns, walk_ew} <= lamp_d;
    end
  end

  assign ped_pend_ns = pend_q[0];
  assign ped_pend_ew = pend_q[1];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_intersection_sched.sv
// Bench for intersection_sched: phase-level reference model with an expected-output
// queue, directed scenarios followed by randomized traffic.
module tb_intersection_sched;

  localparam int GMIN = 5;
  localparam int GMAX = 15;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam int PW   = 7;
  localparam int PER  = 4;

  localparam int PH_RESET  = 0;
  localparam int PH_ALLRED = 1;
  localparam int PH_GREEN  = 2;
  localparam int PH_YELLOW = 3;
  localparam int PH_FLASH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pulse_1s = 1'b0;
  logic req_ns = 1'b0, req_ew = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
  logic nmi_preempt = 1'b0, preempt_dir = 1'b0, nmi_power_outage = 1'b0;
  logic ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  logic walk_ns, walk_ew, ped_pend_ns, ped_pend_ew;
  logic [2:0] dbg_state;
  logic [9:0] dut_vec;

  intersection_sched dut (
    .clk(clk), .reset_n(reset_n), .pulse_1s(pulse_1s),
    .req_ns(req_ns), .req_ew(req_ew), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .nmi_preempt(nmi_preempt), .preempt_dir(preempt_dir), .nmi_power_outage(nmi_power_outage),
    .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .ped_pend_ns(ped_pend_ns), .ped_pend_ew(ped_pend_ew),
    .dbg_state_o(dbg_state)
  );

  assign dut_vec = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
                    walk_ns, walk_ew, ped_pend_ns, ped_pend_ew};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase, pulses spent in phase, walk pulses left
  int   m_phase, m_el, m_walk;
  logic m_dir, m_next, m_togl;
  logic [1:0] m_pend;

  task automatic model_reset();
    m_phase = PH_RESET; m_el = 0; m_walk = 0;
    m_dir = 1'b0; m_next = 1'b0; m_togl = 1'b0; m_pend = 2'b00;
  endtask

  task automatic enter_allred(input logic nd);
    m_phase = PH_ALLRED; m_el = 0; m_next = nd;
  endtask

  task automatic enter_yellow();
    m_phase = PH_YELLOW; m_el = 0; m_walk = 0;
  endtask

  task automatic enter_green(input logic d);
    m_phase = PH_GREEN; m_el = 0; m_dir = d;
    m_walk = m_pend[d] ? PW : 0;
    m_pend[d] = 1'b0;
  endtask

  function automatic logic [7:0] model_lamps();
    logic [7:0] v;
    logic w;
    v = 8'b0;
    w = (m_walk > 0);
    case (m_phase)
      PH_ALLRED: v = {2'b00, 1'b1, 2'b00, 1'b1, 2'b00};
      PH_GREEN:  v = m_dir ? {2'b00, 1'b1, 1'b1, 2'b00, 1'b0, w}
                           : {1'b1, 4'b0000, 1'b1, w, 1'b0};
      PH_YELLOW: v = m_dir ? {2'b00, 1'b1, 1'b0, 1'b1, 3'b000}
                           : {1'b0, 1'b1, 3'b000, 1'b1, 2'b00};
      PH_FLASH:  v = {2'b00, m_togl, 2'b00, m_togl, 2'b00};
      default:   v = 8'b0;
    endcase
    return v;
  endfunction

  task automatic model_pulse();
    int e, walk_pre;
    logic other, own;
    m_togl = ~m_togl;
    if (nmi_power_outage) begin
      m_phase = PH_FLASH;
    end else begin
      case (m_phase)
        PH_RESET:  enter_allred(1'b0);
        PH_ALLRED: if (m_el + 1 >= ART) enter_green(nmi_preempt ? preempt_dir : m_next);
                   else m_el++;
        PH_GREEN: begin
          e = m_el + 1;
          walk_pre = m_walk;
          m_el++;
          if (m_walk > 0) m_walk--;
          other = m_dir ? (req_ns | m_pend[0]) : (req_ew | m_pend[1]);
          own   = m_dir ? req_ew : req_ns;
          if (nmi_preempt) begin
            if (preempt_dir != m_dir) enter_yellow();
          end else if (walk_pre <= 1 && other && e >= GMIN && (!own || e >= GMAX)) begin
            enter_yellow();
          end
        end
        PH_YELLOW: if (m_el + 1 >= YT) enter_allred(~m_dir);
                   else m_el++;
        default:   enter_allred(1'b0);
      endcase
    end
  endtask

  // driver: random knobs apply only in rnd_mode, otherwise inputs are set directly
  logic rnd_mode = 1'b0;
  int k_req = 0, k_ped = 0, k_pre = 0, k_out = 0;

  task automatic cyc(input logic p);
    logic [7:0] lamps;
    pulse_1s = p;
    if (rnd_mode) begin
      req_ns           = ($urandom_range(0, 99) < k_req);
      req_ew           = ($urandom_range(0, 99) < k_req);
      ped_req_ns       = ($urandom_range(0, 99) < k_ped);
      ped_req_ew       = ($urandom_range(0, 99) < k_ped);
      nmi_preempt      = ($urandom_range(0, 99) < k_pre);
      preempt_dir      = 1'($urandom_range(0, 1));
      nmi_power_outage = ($urandom_range(0, 99) < k_out);
    end
    if (!reset_n) begin
      model_reset();
      exp_q.push_back(10'b0);
    end else begin
      lamps = model_lamps();
      if (p) model_pulse();
      if (ped_req_ns) m_pend[0] = 1'b1;
      if (ped_req_ew) m_pend[1] = 1'b1;
      exp_q.push_back({lamps, m_pend[0], m_pend[1]});
    end
    @(posedge clk);
    #1;
    check_eq("lamps", dut_vec, exp_q.pop_front());
  endtask

  task automatic tick();
    cyc(1'b1);
    for (int i = 0; i < PER - 1; i++) cyc(1'b0);
  endtask

  logic g_hist[80];
  int r1, f1, r2, cnt_walk, cnt_green;
  logic found;

  initial begin
    model_reset();
    // reset held: outputs must be zero
    for (int i = 0; i < 3; i++) cyc(1'b0);
    reset_n = 1'b1;
    cyc(1'b0); cyc(1'b0);
    check_eq("reset_idle_outputs", dut_vec, 10'b0);

    // rest: ALLRED after pulse 1, NS green after pulse 3
    tick();
    check_eq("rest_allred", {ns_red, ew_red, ns_green}, 3'b110);
    tick(); tick();
    check_eq("rest_ns_green", ns_green, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    check_eq("rest_hold", {ns_green, ew_red}, 2'b11);

    // gap-out toward EW and back
    req_ew = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    req_ew = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    req_ns = 1'b1;
    tick(); tick();
    req_ns = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    // max-out: both approaches demanding
    req_ns = 1'b1; req_ew = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      g_hist[i] = ns_green;
    end
    r1 = -1; f1 = -1; r2 = -1;
    for (int i = 1; i < 80; i++) begin
      if (r1 < 0 && g_hist[i] && !g_hist[i-1]) r1 = i;
      else if (r1 >= 0 && f1 < 0 && !g_hist[i]) f1 = i;
      else if (f1 >= 0 && r2 < 0 && g_hist[i] && !g_hist[i-1]) r2 = i;
    end
    check_eq("maxout_green_len", f1 - r1, GMAX);
    check_eq("maxout_cycle", r2 - r1, 2 * (GMAX + YT + ART));

    // pedestrian: settle into EW green, then one-clk NS button
    req_ns = 1'b0; req_ew = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    ped_req_ns = 1'b1;
    cyc(1'b0);
    ped_req_ns = 1'b0;
    check_eq("ped_latch", ped_pend_ns, 1'b1);
    cnt_walk = 0; cnt_green = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      cnt_walk  += int'(walk_ns);
      cnt_green += int'(ns_green);
    end
    check_eq("ped_walk_len", cnt_walk, PW);
    check_eq("ped_green_len", cnt_green, PW);
    check_eq("ped_pend_cleared", ped_pend_ns, 1'b0);

    // preemption toward EW during NS walk
    ped_req_ns = 1'b1;
    cyc(1'b0);
    ped_req_ns = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = (m_phase == PH_GREEN && m_dir == 1'b0 && m_walk > 0);
    end
    check_eq("reach_ns_walk", found, 1'b1);
    nmi_preempt = 1'b1; preempt_dir = 1'b1; req_ns = 1'b1;
    tick();
    check_eq("preempt_yellow", {ns_yellow, walk_ns, ew_red}, 3'b101);
    for (int i = 0; i < 25; i++) tick();
    check_eq("preempt_hold_ew", ew_green, 1'b1);
    nmi_preempt = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    // power outage flash and recovery
    req_ns = 1'b0; req_ew = 1'b0;
    nmi_power_outage = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("flash_others", {ns_green, ns_yellow, ew_green, ew_yellow, walk_ns, walk_ew}, 6'b0);
    check_eq("flash_reds_equal", ns_red ^ ew_red, 1'b0);
    nmi_power_outage = 1'b0;
    tick();
    check_eq("outage_allred1", {ns_red, ew_red, ns_green}, 3'b110);
    tick();
    check_eq("outage_allred2", {ns_red, ew_red, ns_green}, 3'b110);
    tick();
    check_eq("outage_ns_green", ns_green, 1'b1);

    // asynchronous reset in the middle of yellow
    req_ns = 1'b1; req_ew = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = (m_phase == PH_YELLOW);
    end
    check_eq("reach_yellow", found, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset", dut_vec, 10'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // randomized traffic
    rnd_mode = 1'b1;
    k_req = 50; k_ped = 5;  k_pre = 5;  k_out = 1;
    for (int i = 0; i < 600; i++) tick();
    k_req = 80; k_ped = 2;  k_pre = 0;  k_out = 0;
    for (int i = 0; i < 600; i++) tick();
    k_req = 30; k_ped = 10; k_pre = 15; k_out = 3;
    for (int i = 0; i < 600; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
